// File: rtl/qaccum.sv
// Streaming Q-format frame accumulator with valid/ready handshake on both sides.
// Optional saturating adds are compiled in with `define QACCUM_SAT_EN.
module qaccum #(
    parameter int Q   = 15,
    parameter int N   = 32,
    parameter int LEN = 8,
    localparam int CW = $clog2(LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [CW-1:0] out_count,
    output logic          out_ovf
);

    if (Q < 0 || Q > N - 1 || LEN < 1) begin : g_bad_param
        $error("qaccum: illegal Q/N/LEN combination");
    end

    typedef enum logic {StAcc, StHold} state_e;

    state_e        state_q;
    logic [N-1:0]  acc_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          out_valid_q;
    logic [N-1:0]  out_data_q;
    logic [CW-1:0] out_count_q;
    logic          out_ovf_q;

    logic [N-1:0]  sum_wrap;
    logic [N-1:0]  sum;
    logic [CW-1:0] count_inc;
    logic          add_ovf;
    logic          ovf_next;
    logic          accept;
    logic          frame_end;

`ifdef QACCUM_SAT_EN
    localparam logic [N-1:0] MaxPos = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MinNeg = {1'b1, {(N-1){1'b0}}};
`endif

    assign in_ready  = (state_q == StAcc);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        accept   = in_valid && in_ready;
        sum_wrap = acc_q + in_data;
        // Same-sign operands producing a result of the opposite sign.
        add_ovf  = (acc_q[N-1] == in_data[N-1]) && (sum_wrap[N-1] != acc_q[N-1]);
`ifdef QACCUM_SAT_EN
        if (add_ovf) begin
            sum = acc_q[N-1] ? MinNeg : MaxPos;
        end else begin
            sum = sum_wrap;
        end
`else
        sum = sum_wrap;
`endif
        ovf_next  = ovf_q | add_ovf;
        count_inc = count_q + CW'(1);
        frame_end = accept && (in_last || count_inc == CW'(LEN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAcc;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (frame_end) begin
                        out_data_q  <= sum;
                        out_count_q <= count_inc;
                        out_ovf_q   <= ovf_next;
                        out_valid_q <= 1'b1;
                        state_q     <= StHold;
                    end else if (accept) begin
                        acc_q   <= sum;
                        count_q <= count_inc;
                        ovf_q   <= ovf_next;
                    end
                end
                StHold: begin
                    // Result registers stay untouched until the consumer takes them.
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        count_q     <= '0;
                        ovf_q       <= 1'b0;
                        state_q     <= StAcc;
                    end
                end
            endcase
        end
    end

endmodule
